eaglesong_sponge_driver: RTL and testbench



---
 rtl/eaglesong_sponge_driver_if.sv | 28 ++
 rtl/eaglesong_sponge_driver.sv | 141 ++++++++++++++
 tb/tb_eaglesong_sponge_driver.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eaglesong_sponge_driver_if.sv
// Bundles the message stream, permutation-core handshake and digest hand-off of the
// Eaglesong sponge driver. The slave modport is the driver; the master modport is its environment.
interface eaglesong_sponge_driver_if #(
  parameter int OUT_WORDS = 8
);
  logic [31:0]                in_data;
  logic                       in_valid;
  logic                       in_last;
  logic [2:0]                 in_bytes;
  logic                       in_ready;
  logic [15:0][31:0]          perm_state_in;
  logic                       perm_start;
  logic [15:0][31:0]          perm_state_out;
  logic                       perm_ready;
  logic [OUT_WORDS-1:0][31:0] digest;
  logic                       digest_valid;
  logic                       digest_ack;

  modport slave (
    input  in_data, in_valid, in_last, in_bytes, perm_state_out, perm_ready, digest_ack,
    output in_ready, perm_state_in, perm_start, digest, digest_valid
  );

  modport master (
    output in_data, in_valid, in_last, in_bytes, perm_state_out, perm_ready, digest_ack,
    input  in_ready, perm_state_in, perm_start, digest, digest_valid
  );
endinterface

// File: rtl/eaglesong_sponge_driver.sv
// Eaglesong sponge initiator: pads and absorbs a byte-granular word stream, drives the
// permutation core through start/ready, and presents the squeezed digest until acknowledged.
module eaglesong_sponge_driver #(
  parameter int         RATE_WORDS = 8,
  parameter logic [7:0] DELIM      = 8'h06,
  parameter int         OUT_WORDS  = 8
) (
  input logic                     clk,
  input logic                     rst,
  eaglesong_sponge_driver_if.slave bus
);

  typedef enum logic [2:0] {ABSORB, PAD, PERM_START, PERM_WAIT, DONE} fsm_e;

  localparam logic [4:0] RATE_CNT = 5'(RATE_WORDS);

  fsm_e                       fsm_q;
  logic [15:0][31:0]          state_q;
  logic [4:0]                 cnt_q;
  logic                       pad_pending_q;
  logic                       final_q;
  logic                       ready_prev_q;
  logic                       in_ready_q;
  logic                       perm_start_q;
  logic [OUT_WORDS-1:0][31:0] digest_q;
  logic                       digest_valid_q;

  logic [2:0]  nb;
  logic [31:0] absorb_word;
  logic [4:0]  cnt_inc;
  logic        accept;
  logic        perm_done;

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    nb = 3'd4;
    if (bus.in_last && (bus.in_bytes < 3'd4)) nb = bus.in_bytes;
    absorb_word = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(nb))       absorb_word[31-8*k -: 8] = bus.in_data[31-8*k -: 8];
      else if (k == int'(nb)) absorb_word[31-8*k -: 8] = DELIM;
    end
  end

  assign accept    = bus.in_valid && in_ready_q;
  // Only a fresh rising edge counts; a level left high from the previous run is stale.
  assign perm_done = bus.perm_ready && !ready_prev_q;
  assign cnt_inc   = cnt_q + 5'd1;

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the sponge state array is reset explicitly because a new message must absorb into zeros.
      fsm_q          <= ABSORB;
      state_q        <= '0;
      cnt_q          <= '0;
      pad_pending_q  <= 1'b0;
      final_q        <= 1'b0;
      ready_prev_q   <= 1'b0;
      in_ready_q     <= 1'b0;
      perm_start_q   <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      ready_prev_q <= bus.perm_ready;
      perm_start_q <= 1'b0;
      unique case (fsm_q)
        ABSORB: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            state_q[cnt_q[3:0]] <= state_q[cnt_q[3:0]] ^ absorb_word;
            cnt_q               <= cnt_inc;
            if (bus.in_last && (nb != 3'd4)) begin
              final_q       <= 1'b1;
              pad_pending_q <= 1'b0;
              in_ready_q    <= 1'b0;
              perm_start_q  <= 1'b1;
              fsm_q         <= PERM_START;
            end else if (bus.in_last) begin
              in_ready_q <= 1'b0;
              fsm_q      <= PAD;
            end else if (cnt_inc == RATE_CNT) begin
              final_q       <= 1'b0;
              pad_pending_q <= 1'b0;
              in_ready_q    <= 1'b0;
              perm_start_q  <= 1'b1;
              fsm_q         <= PERM_START;
            end
          end
        end
        PAD: begin
          perm_start_q <= 1'b1;
          fsm_q        <= PERM_START;
          // A full block must be permuted before the padding-only block can start.
          if (cnt_q == RATE_CNT) begin
            pad_pending_q <= 1'b1;
          end else begin
            state_q[cnt_q[3:0]] <= state_q[cnt_q[3:0]] ^ {DELIM, 24'h0};
            final_q             <= 1'b1;
          end
        end
        PERM_START: fsm_q <= PERM_WAIT;
        PERM_WAIT: begin
          if (perm_done) begin
            state_q <= bus.perm_state_out;
            cnt_q   <= '0;
            if (final_q) begin
              final_q        <= 1'b0;
              digest_q       <= bus.perm_state_out[OUT_WORDS-1:0];
              digest_valid_q <= 1'b1;
              fsm_q          <= DONE;
            end else if (pad_pending_q) begin
              pad_pending_q <= 1'b0;
              fsm_q         <= PAD;
            end else begin
              in_ready_q <= 1'b1;
              fsm_q      <= ABSORB;
            end
          end
        end
        DONE: begin
          if (bus.digest_ack && digest_valid_q) begin
            digest_valid_q <= 1'b0;
            state_q        <= '0;
            cnt_q          <= '0;
            in_ready_q     <= 1'b1;
            fsm_q          <= ABSORB;
          end
        end
        default: fsm_q <= ABSORB;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.perm_state_in = state_q;
  assign bus.perm_start    = perm_start_q;
  assign bus.digest        = digest_q;
  assign bus.digest_valid  = digest_valid_q;

endmodule

// File: tb/tb_eaglesong_sponge_driver.sv
// Bench for eaglesong_sponge_driver: a stub permutation core plus a byte-level padding and
// sponge model that predicts every permuted block and the final digest.
module tb_eaglesong_sponge_driver;

  localparam logic [7:0] DELIM = 8'h06;
  typedef logic [15:0][31:0] st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  eaglesong_sponge_driver_if #(.OUT_WORDS(8)) bus ();

  eaglesong_sponge_driver #(
    .RATE_WORDS(8),
    .DELIM     (8'h06),
    .OUT_WORDS (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  bit   scramble = 1'b0;
  bit   stale    = 1'b0;
  st_t  seen_blocks[$];
  int   rdy_viol = 0;
  int   lat_cnt  = 0;
  st_t  latched;
  logic stub_ready = 1'b0;
  st_t  stub_out   = '0;

  assign bus.perm_ready     = stub_ready;
  assign bus.perm_state_out = stub_out;

  // Stand-in permutation: identity, or a fixed word shuffle when scramble is set.
  function automatic st_t perm_f(input st_t s, input bit scr);
    st_t r;
    if (!scr) return s;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] w;
      w    = s[(i + 5) % 16];
      r[i] = {w[30:0], w[31]} ^ (32'h01000193 * 32'(i + 1));
    end
    return r;
  endfunction

  function automatic logic [31:0] or_words(input st_t s);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) acc |= s[i];
    return acc;
  endfunction

  // Stub core: output is garbage until ready rises; stale mode keeps ready high past the start.
  always @(negedge clk) begin
    if ((bus.perm_start || lat_cnt > 0) && bus.in_ready) rdy_viol++;
    if (bus.perm_start) begin
      latched = bus.perm_state_in;
      seen_blocks.push_back(latched);
      lat_cnt    = stale ? 4 : 3;
      stub_ready = stale;
      stub_out   = {16{32'hBAD0BAD0}};
    end else if (lat_cnt > 0) begin
      lat_cnt--;
      stub_ready = stale ? (lat_cnt >= 3 || lat_cnt == 0) : (lat_cnt == 0);
      if (lat_cnt == 0) stub_out = perm_f(latched, scramble);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_msg(input logic [7:0] msg[$], input bit gaps, input string name);
    int          len, nw, j, guard;
    logic [31:0] wd;
    len   = msg.size();
    nw    = (len == 0) ? 1 : (len + 3) / 4;
    j     = 0;
    guard = 0;
    while (j < nw && guard < 2000) begin
      if (gaps && $urandom_range(3) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        for (int k = 0; k < 4; k++)
          wd[31-8*k -: 8] = (4*j + k < len) ? msg[4*j + k] : 8'($urandom);
        bus.in_data  = wd;
        bus.in_valid = 1'b1;
        bus.in_last  = (j == nw - 1);
        bus.in_bytes = (j == nw - 1) ? 3'(len - 4*j) : 3'($urandom_range(7));
      end
      if (bus.in_valid && bus.in_ready) j++;
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b0;
    check({name, " words accepted"}, 32'(j), 32'(nw));
  endtask

  task automatic run_msg(input logic [7:0] msg[$], input bit gaps, input string name);
    logic [7:0] pad[$];
    st_t        st;
    st_t        exp_in[$];
    int         base_blk, base_viol, guard;
    pad = msg;
    pad.push_back(DELIM);
    while (pad.size() % 32 != 0) pad.push_back(8'h00);
    st = '0;
    for (int b = 0; b < pad.size() / 32; b++) begin
      for (int w = 0; w < 8; w++)
        st[w] ^= {pad[b*32 + 4*w], pad[b*32 + 4*w + 1], pad[b*32 + 4*w + 2], pad[b*32 + 4*w + 3]};
      exp_in.push_back(st);
      st = perm_f(st, scramble);
    end

    base_blk  = seen_blocks.size();
    base_viol = rdy_viol;
    send_msg(msg, gaps, name);
    guard = 0;
    while (!bus.digest_valid && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check({name, " digest_valid"}, 32'(bus.digest_valid), 32'd1);
    check({name, " perm count"}, 32'(seen_blocks.size() - base_blk), 32'(exp_in.size()));
    for (int b = 0; b < exp_in.size() && base_blk + b < seen_blocks.size(); b++)
      for (int w = 0; w < 16; w++)
        check($sformatf("%s blk%0d w%0d", name, b, w), seen_blocks[base_blk + b][w], exp_in[b][w]);
    for (int w = 0; w < 8; w++)
      check($sformatf("%s digest w%0d", name, w), bus.digest[w], st[w]);
    check({name, " in_ready low in DONE"}, 32'(bus.in_ready), 32'd0);
    check({name, " in_ready during perm"}, 32'(rdy_viol - base_viol), 32'd0);
    repeat ($urandom_range(3)) @(negedge clk);
    check({name, " digest held"}, 32'(bus.digest_valid), 32'd1);
    bus.digest_ack = 1'b1;
    @(negedge clk);
    bus.digest_ack = 1'b0;
    check({name, " digest_valid cleared"}, 32'(bus.digest_valid), 32'd0);
    check({name, " in_ready after ack"}, 32'(bus.in_ready), 32'd1);
    check({name, " state cleared"}, or_words(bus.perm_state_in), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m[$];
    string      s;
    int         nb0, base;

    // NOTE: inputs are driven with blocking assignments at the falling edge, away from the sampling edge.
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.in_bytes   = '0;
    bus.digest_ack = 1'b0;

    repeat (3) @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset perm_start", 32'(bus.perm_start), 32'd0);
    check("reset digest_valid", 32'(bus.digest_valid), 32'd0);
    check("reset digest w0", bus.digest[0], 32'd0);
    check("reset state", or_words(bus.perm_state_in), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after reset", 32'(bus.in_ready), 32'd1);

    // Empty message on the identity core.
    m = {};
    nb0 = seen_blocks.size();
    run_msg(m, 1'b0, "empty");
    check("empty block w0", seen_blocks[nb0][0], 32'h06000000);

    // "Hello, world!\n": the last word carries two bytes then the delimiter.
    s = "Hello, world!\n";
    m = {};
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    nb0 = seen_blocks.size();
    run_msg(m, 1'b0, "hello");
    check("hello block w0", seen_blocks[nb0][0], 32'h48656C6C);
    check("hello block w3", seen_blocks[nb0][3], 32'h210A0600);

    // 32-byte message: the padding-only block costs a second permutation.
    m = {};
    for (int i = 0; i < 32; i++) m.push_back(8'($urandom));
    nb0 = seen_blocks.size();
    run_msg(m, 1'b1, "len32");
    check("len32 pad block w0", seen_blocks[nb0 + 1][0], {m[0], m[1], m[2], m[3]} ^ 32'h06000000);

    // Continuous valid across a block boundary with a stale ready level at each start.
    scramble = 1'b1;
    stale    = 1'b1;
    m = {};
    for (int i = 0; i < 45; i++) m.push_back(8'($urandom));
    run_msg(m, 1'b0, "stale45");
    m = {};
    for (int i = 0; i < 7; i++) m.push_back(8'($urandom));
    run_msg(m, 1'b0, "after_stale");

    for (int r = 0; r < 8; r++) begin
      stale = 1'($urandom_range(1));
      m = {};
      for (int i = 0, n = $urandom_range(72); i < n; i++) m.push_back(8'($urandom));
      run_msg(m, 1'($urandom_range(1)), $sformatf("rand%0d", r));
    end

    // Reset in the middle of a permutation wait aborts the message.
    stale = 1'b0;
    m = {};
    for (int i = 0; i < 10; i++) m.push_back(8'($urandom));
    base = seen_blocks.size();
    send_msg(m, 1'b0, "abort");
    for (int g = 0; g < 20 && seen_blocks.size() == base; g++) @(negedge clk);
    check("abort perm started", 32'(seen_blocks.size() - base), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready", 32'(bus.in_ready), 32'd0);
    check("abort perm_start", 32'(bus.perm_start), 32'd0);
    check("abort digest_valid", 32'(bus.digest_valid), 32'd0);
    check("abort digest w0", bus.digest[0], 32'd0);
    check("abort state", or_words(bus.perm_state_in), 32'd0);
    repeat (6) @(negedge clk);
    check("abort late ready ignored", 32'(bus.digest_valid), 32'd0);
    check("abort no extra start", 32'(seen_blocks.size() - base), 32'd1);
    check("abort in_ready idle", 32'(bus.in_ready), 32'd1);
    scramble = 1'b0;
    m = {};
    run_msg(m, 1'b0, "empty_after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
